regfile_nport: RTL and testbench
================================

REGFILE_NPORT -- requirements
Module: regfile_nport

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, 8..64); ADDRW = log2(NREG).
REQ-003 SHALL have parameter NLANE, default 2, meaning issue lanes (1..4); lane index order = program order.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clock_i, reset_i.
REQ-005 clock_i  in  1  rising-edge clock.
REQ-006 reset_i  in  1  synchronous active-high reset.
REQ-007 rs1_addr_i / rs2_addr_i  in  NLANE*ADDRW  per-lane source addresses.
REQ-008 rd_addr_i  in  NLANE*ADDRW; rd_data_i  in  NLANE*XLEN; rd_write_i  in  NLANE  per-lane writeback.
REQ-009 claim_addr_i  in  NLANE*ADDRW; claim_valid_i  in  NLANE  per-lane destination reservation.
REQ-010 rs1_data_o / rs2_data_o  out  NLANE*XLEN  per-lane read data.
REQ-011 rs1_busy_o / rs2_busy_o  out  NLANE  source has a pending write.
REQ-012 ready_o  out  1  high once the initialisation sweep is complete.

Function
REQ-013 Read latency SHALL be one cycle: addresses sampled at edge t; data and busy valid throughout cycle t+1 and reflect all writes committed at or before edge t.
REQ-014 Register 0 SHALL always read 0 and never be busy; writes and claims to it are ignored.
REQ-015 Multiple lanes writing the same rd in one cycle: highest-index lane SHALL win.
REQ-016 Scoreboard: one busy bit per register; claim sets it, rd_write_i clears it, both at the edge.
REQ-017 Claim and writeback to the same register in one cycle: claim SHALL win (bit stays set).
REQ-018 Writeback to a non-busy register SHALL still update data; busy unchanged.
REQ-019 FSM states INIT, RUN; INIT uses a counter 0..NREG-1 writing zero to one register per cycle; after NREG cycles -> RUN, ready_o=1.
REQ-020 In INIT, rd_write_i and claim_valid_i SHALL be ignored; data outputs read 0; busy outputs 0.
REQ-021 Sweep counter SHALL stop at NREG-1 (no wrap); RUN is terminal until reset.

Reset
REQ-022 reset_i high at any edge (including mid-sweep or mid-operation) SHALL enter INIT, counter=0, clear all busy bits, clear sampled addresses, ready_o=0.
REQ-023 Register contents SHALL be zeroed only by the sweep, not by reset directly.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN: defined -> a write presented in cycle t+1 to an address being read in t+1 SHALL appear on data outputs in the same cycle (combinational write-through, same lane priority as REQ-015), and busy for that address reads 0 unless claimed that cycle; undefined -> data reflects the array only (REQ-013).

Structure
REQ-025 Shared package SHALL hold the INIT/RUN state enum and default XLEN/NREG/NLANE constants.
REQ-026 One sub-module rf_scoreboard (busy bits, claim/clear priority, busy lookups) SHALL be instantiated; array, sweep FSM and bypass remain in regfile_nport.

Verification
REQ-027 Reset, then NREG cycles idle -> ready_o rises on cycle NREG+1; every register reads 0.
REQ-028 Lane0 and lane1 both write x5 (0x11, 0x22) same cycle -> later read of x5 = 0x22.
REQ-029 Write x0=0xFFFFFFFF with claim x0 -> x0 reads 0, never busy.
REQ-030 Claim x7; next cycle writeback x7 and claim x7 together -> rs1_busy_o stays 1; writeback alone next -> busy 0.
REQ-031 With REGFILE_BYPASS_EN: read x3 issued at t, write x3=0xABCD at t+1 -> rs1_data_o=0xABCD in t+1; without the macro the old value.
REQ-032 Assert reset_i at sweep cycle 10 -> ready_o 0, sweep restarts at 0, write attempts during INIT have no effect.

Source files
------------

// File: rtl/regfile_nport_pkg.sv
// -----------------------------------------------------------------------------
// regfile_nport_pkg
// Shared definitions for the multi-lane register file: controller states and
// the default geometry (register width, register count, issue lanes).
// No ports.
// -----------------------------------------------------------------------------
package regfile_nport_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREG  = 32;
  localparam int RF_NLANE = 2;

  // INIT: zeroing sweep in progress, RUN: normal operation (terminal until reset)
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_nport_if.sv
// -----------------------------------------------------------------------------
// regfile_nport_if
// Bundles the per-lane read, writeback, reservation and status signals of the
// register file. Lane l occupies bits [l*W +: W] of each packed vector, lane
// index = program order.
//   master : the pipeline side (drives addresses, writebacks, claims)
//   slave  : the register file side (drives read data, busy flags, ready)
// Signals:
//   rs1_addr_i/rs2_addr_i  NLANE*ADDRW  source addresses
//   rd_addr_i/rd_data_i/rd_write_i      writeback per lane
//   claim_addr_i/claim_valid_i          destination reservation per lane
//   rs1_data_o/rs2_data_o  NLANE*XLEN   read data
//   rs1_busy_o/rs2_busy_o  NLANE        source has a pending write
//   ready_o                             initialisation sweep complete
// -----------------------------------------------------------------------------
interface regfile_nport_if
  import regfile_nport_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREG  = RF_NREG,
  parameter int NLANE = RF_NLANE
);
  localparam int ADDRW = $clog2(NREG);

  logic [NLANE*ADDRW-1:0] rs1_addr_i;
  logic [NLANE*ADDRW-1:0] rs2_addr_i;
  logic [NLANE*ADDRW-1:0] rd_addr_i;
  logic [NLANE*XLEN-1:0]  rd_data_i;
  logic [NLANE-1:0]       rd_write_i;
  logic [NLANE*ADDRW-1:0] claim_addr_i;
  logic [NLANE-1:0]       claim_valid_i;
  logic [NLANE*XLEN-1:0]  rs1_data_o;
  logic [NLANE*XLEN-1:0]  rs2_data_o;
  logic [NLANE-1:0]       rs1_busy_o;
  logic [NLANE-1:0]       rs2_busy_o;
  logic                   ready_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, rd_write_i,
           claim_addr_i, claim_valid_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, ready_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, rd_write_i,
           claim_addr_i, claim_valid_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, ready_o
  );

endinterface

// File: rtl/regfile_nport_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per register. A claim sets the bit, a writeback clears it; when
// both hit the same register on one edge the claim wins. Register 0 is never
// busy. Lookups return the bit for each lane's (already sampled) read address.
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset (clears all)
//   i_en                    updates accepted only when high (RUN state)
//   i_rd_addr/i_rd_write    per-lane writebacks (clear)
//   i_claim_addr/i_claim_valid per-lane reservations (set)
//   i_rs1_addr/i_rs2_addr   per-lane lookup addresses
//   o_rs1_busy/o_rs2_busy   per-lane busy flags
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int NREG  = 32,
  parameter int NLANE = 2,
  parameter int ADDRW = $clog2(NREG)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   i_en,
  input  logic [NLANE*ADDRW-1:0] i_rd_addr,
  input  logic [NLANE-1:0]       i_rd_write,
  input  logic [NLANE*ADDRW-1:0] i_claim_addr,
  input  logic [NLANE-1:0]       i_claim_valid,
  input  logic [NLANE*ADDRW-1:0] i_rs1_addr,
  input  logic [NLANE*ADDRW-1:0] i_rs2_addr,
  output logic [NLANE-1:0]       o_rs1_busy,
  output logic [NLANE-1:0]       o_rs2_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  // Next busy vector: clears first, then claims, so a claim overrides a clear
  always_comb begin
    w_busy_next = r_busy;
    if (i_en) begin
      for (int w = 0; w < NLANE; w++) begin
        if (i_rd_write[w]) begin
          w_busy_next[i_rd_addr[w*ADDRW +: ADDRW]] = 1'b0;
        end else begin
          w_busy_next = w_busy_next;
        end
      end
      for (int w = 0; w < NLANE; w++) begin
        if (i_claim_valid[w]) begin
          w_busy_next[i_claim_addr[w*ADDRW +: ADDRW]] = 1'b1;
        end else begin
          w_busy_next = w_busy_next;
        end
      end
    end else begin
      w_busy_next = r_busy;
    end
    // x0 is hard-wired: never reserved
    w_busy_next[0] = 1'b0;
  end

  // Busy bit storage
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Per-lane busy lookups
  always_comb begin
    o_rs1_busy = '0;
    o_rs2_busy = '0;
    for (int l = 0; l < NLANE; l++) begin
      o_rs1_busy[l] = r_busy[i_rs1_addr[l*ADDRW +: ADDRW]];
      o_rs2_busy[l] = r_busy[i_rs2_addr[l*ADDRW +: ADDRW]];
    end
  end

endmodule

// File: rtl/regfile_nport.sv
// -----------------------------------------------------------------------------
// regfile_nport
// Multi-lane register file with a busy-bit scoreboard and a zeroing sweep after
// reset. Reads have one cycle of latency: addresses are sampled on an edge and
// the array (plus busy bits) is looked up during the following cycle.
// After reset the controller spends NREG cycles in INIT writing zero to one
// register per cycle; writebacks and claims are ignored and all outputs read 0
// until RUN, when ready_o goes high.
// Ports:
//   clock_i   rising-edge clock
//   reset_i   synchronous active-high reset (INIT, busy cleared, addresses
//             cleared; array contents are zeroed only by the sweep)
//   rf_bus    regfile_nport_if.slave, see interface header
// Optional feature (macro REGFILE_BYPASS_EN): a writeback presented in the
// read cycle to the address being read is forwarded combinationally to the
// data output (highest lane wins), and busy for that address then reads 0
// unless it is also claimed in that cycle.
// -----------------------------------------------------------------------------
module regfile_nport
  import regfile_nport_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREG  = RF_NREG,
  parameter int NLANE = RF_NLANE
) (
  input logic            clock_i,
  input logic            reset_i,
  regfile_nport_if.slave rf_bus
);

  localparam int ADDRW = $clog2(NREG);

  rf_state_e              r_state;
  rf_state_e              w_state_next;
  logic [ADDRW-1:0]       r_sweep_cnt;
  logic [ADDRW-1:0]       w_sweep_cnt_next;
  logic                   r_ready;
  logic                   w_ready_next;
  logic [NLANE*ADDRW-1:0] r_rs1_addr;
  logic [NLANE*ADDRW-1:0] r_rs2_addr;
  logic [XLEN-1:0]        r_mem [NREG];

  logic [NLANE-1:0]       w_sb_rs1_busy;
  logic [NLANE-1:0]       w_sb_rs2_busy;
  logic [NLANE*XLEN-1:0]  w_rs1_data;
  logic [NLANE*XLEN-1:0]  w_rs2_data;
  logic [NLANE-1:0]       w_rs1_busy;
  logic [NLANE-1:0]       w_rs2_busy;
  logic [ADDRW-1:0]       w_addr;
  logic [XLEN-1:0]        w_data;
  logic                   w_busy;
  logic                   w_run;
`ifdef REGFILE_BYPASS_EN
  logic                   w_hit;
  logic                   w_claimed;
`endif

  assign w_run = (r_state == ST_RUN);

  // Sweep FSM next state: counter stops at NREG-1, RUN is terminal
  always_comb begin
    w_state_next     = r_state;
    w_sweep_cnt_next = r_sweep_cnt;
    w_ready_next     = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_sweep_cnt == ADDRW'(NREG - 1)) begin
          w_state_next = ST_RUN;
          w_ready_next = 1'b1;
        end else begin
          w_sweep_cnt_next = r_sweep_cnt + ADDRW'(1);
        end
      end
      ST_RUN: begin
        w_ready_next = 1'b1;
      end
      default: begin
        w_state_next     = ST_INIT;
        w_sweep_cnt_next = '0;
      end
    endcase
  end

  // Controller state, sweep counter, ready flag and sampled read addresses
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= '0;
      r_ready     <= 1'b0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_cnt <= w_sweep_cnt_next;
      r_ready     <= w_ready_next;
      r_rs1_addr  <= rf_bus.rs1_addr_i;
      r_rs2_addr  <= rf_bus.rs2_addr_i;
    end
  end

  // Register array: sweep zeroing in INIT, lane writebacks in RUN.
  // Later lanes are written last so the highest lane wins on a collision.
  always_ff @(posedge clock_i) begin
    if (r_state == ST_INIT) begin
      r_mem[r_sweep_cnt] <= '0;
    end else if (!reset_i) begin
      for (int w = 0; w < NLANE; w++) begin
        if (rf_bus.rd_write_i[w] && (rf_bus.rd_addr_i[w*ADDRW +: ADDRW] != '0)) begin
          r_mem[rf_bus.rd_addr_i[w*ADDRW +: ADDRW]] <= rf_bus.rd_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREG  (NREG),
    .NLANE (NLANE),
    .ADDRW (ADDRW)
  ) u_scoreboard (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .i_en          (w_run),
    .i_rd_addr     (rf_bus.rd_addr_i),
    .i_rd_write    (rf_bus.rd_write_i),
    .i_claim_addr  (rf_bus.claim_addr_i),
    .i_claim_valid (rf_bus.claim_valid_i),
    .i_rs1_addr    (r_rs1_addr),
    .i_rs2_addr    (r_rs2_addr),
    .o_rs1_busy    (w_sb_rs1_busy),
    .o_rs2_busy    (w_sb_rs2_busy)
  );

  // Read ports: p=0 is rs1, p=1 is rs2; x0 and the INIT state force zeros
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    w_rs1_busy = '0;
    w_rs2_busy = '0;
    w_addr     = '0;
    w_data     = '0;
    w_busy     = 1'b0;
`ifdef REGFILE_BYPASS_EN
    w_hit      = 1'b0;
    w_claimed  = 1'b0;
`endif
    for (int l = 0; l < NLANE; l++) begin
      for (int p = 0; p < 2; p++) begin
        w_addr = (p == 0) ? r_rs1_addr[l*ADDRW +: ADDRW] : r_rs2_addr[l*ADDRW +: ADDRW];
        w_data = r_mem[w_addr];
        w_busy = (p == 0) ? w_sb_rs1_busy[l] : w_sb_rs2_busy[l];
`ifdef REGFILE_BYPASS_EN
        // Forward this cycle's writeback; a same-cycle claim keeps it busy
        w_hit     = 1'b0;
        w_claimed = 1'b0;
        for (int w = 0; w < NLANE; w++) begin
          if (rf_bus.rd_write_i[w] && (rf_bus.rd_addr_i[w*ADDRW +: ADDRW] == w_addr)) begin
            w_hit  = 1'b1;
            w_data = rf_bus.rd_data_i[w*XLEN +: XLEN];
          end else begin
            w_hit = w_hit;
          end
          if (rf_bus.claim_valid_i[w] && (rf_bus.claim_addr_i[w*ADDRW +: ADDRW] == w_addr)) begin
            w_claimed = 1'b1;
          end else begin
            w_claimed = w_claimed;
          end
        end
        if (w_hit) begin
          w_busy = w_claimed;
        end else begin
          w_busy = w_busy;
        end
`endif
        if (!w_run || (w_addr == '0)) begin
          w_data = '0;
          w_busy = 1'b0;
        end else begin
          w_data = w_data;
        end
        if (p == 0) begin
          w_rs1_data[l*XLEN +: XLEN] = w_data;
          w_rs1_busy[l]              = w_busy;
        end else begin
          w_rs2_data[l*XLEN +: XLEN] = w_data;
          w_rs2_busy[l]              = w_busy;
        end
      end
    end
  end

  assign rf_bus.rs1_data_o = w_rs1_data;
  assign rf_bus.rs2_data_o = w_rs2_data;
  assign rf_bus.rs1_busy_o = w_rs1_busy;
  assign rf_bus.rs2_busy_o = w_rs2_busy;
  assign rf_bus.ready_o    = r_ready;

endmodule

// File: tb/tb_regfile_nport.sv
// -----------------------------------------------------------------------------
// tb_regfile_nport
// Self-checking bench for regfile_nport (default geometry 32x32, 2 lanes).
// Directed table of cycle vectors, hand sequences for reset/sweep timing, then
// randomized traffic checked against a behavioural model. Honors
// REGFILE_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_regfile_nport;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NLANE = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  regfile_nport_if #(.XLEN(XLEN), .NREG(NREG), .NLANE(NLANE)) rf_bus ();

  regfile_nport #(.XLEN(XLEN), .NREG(NREG), .NLANE(NLANE)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .rf_bus  (rf_bus)
  );

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_mem  [NREG];
  logic            m_busy [NREG];
  int              m_cycles = 0;     // edges since the last reset edge, capped at NREG
  logic [AW-1:0]   m_ra [2][NLANE];

  always @(posedge clk) begin
    if (rst) begin
      m_cycles <= 0;
      for (int r = 0; r < NREG; r++) m_busy[r] <= 1'b0;
      for (int l = 0; l < NLANE; l++) begin
        m_ra[0][l] <= '0;
        m_ra[1][l] <= '0;
      end
    end else begin
      if (m_cycles < NREG) m_cycles <= m_cycles + 1;
      if (m_cycles == NREG - 1) begin
        for (int r = 0; r < NREG; r++) m_mem[r] <= '0;
      end
      if (m_cycles >= NREG) begin
        for (int l = 0; l < NLANE; l++) begin
          if (rf_bus.rd_write_i[l] && rf_bus.rd_addr_i[l*AW +: AW] != 0) begin
            m_mem[rf_bus.rd_addr_i[l*AW +: AW]]  <= rf_bus.rd_data_i[l*XLEN +: XLEN];
            m_busy[rf_bus.rd_addr_i[l*AW +: AW]] <= 1'b0;
          end
        end
        for (int l = 0; l < NLANE; l++) begin
          if (rf_bus.claim_valid_i[l] && rf_bus.claim_addr_i[l*AW +: AW] != 0)
            m_busy[rf_bus.claim_addr_i[l*AW +: AW]] <= 1'b1;
        end
      end
      for (int l = 0; l < NLANE; l++) begin
        m_ra[0][l] <= rf_bus.rs1_addr_i[l*AW +: AW];
        m_ra[1][l] <= rf_bus.rs2_addr_i[l*AW +: AW];
      end
    end
  end

  function automatic void model_read(input int p, input int l,
                                     output logic [XLEN-1:0] d, output logic b);
    logic [AW-1:0] a;
    logic hit, cl;
    a = m_ra[p][l];
    d = '0;
    b = 1'b0;
    hit = 1'b0;
    cl = 1'b0;
    if (m_cycles >= NREG && a != 0) begin
      d = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NLANE; w++) begin
        if (rf_bus.rd_write_i[w] && rf_bus.rd_addr_i[w*AW +: AW] == a) begin
          hit = 1'b1;
          d = rf_bus.rd_data_i[w*XLEN +: XLEN];
        end
        if (rf_bus.claim_valid_i[w] && rf_bus.claim_addr_i[w*AW +: AW] == a) cl = 1'b1;
      end
      if (hit) b = cl;
`endif
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rf_bus.rd_write_i    = '0;
    rf_bus.rd_addr_i     = '0;
    rf_bus.rd_data_i     = '0;
    rf_bus.claim_valid_i = '0;
    rf_bus.claim_addr_i  = '0;
    rf_bus.rs1_addr_i    = '0;
    rf_bus.rs2_addr_i    = '0;
  endtask

  // Called at the start of cycle 1 after the last reset edge; returns the
  // cycle number where ready_o is first seen (or -1). With junk set, writes
  // x1 and claims x2 on every INIT cycle.
  task automatic wait_ready(input bit junk, output int rise);
    rise = -1;
    for (int c = 1; c <= NREG + 8; c++) begin
      if (junk) begin
        rf_bus.rd_write_i    = 2'b01;
        rf_bus.rd_addr_i     = {5'd0, 5'd1};
        rf_bus.rd_data_i     = {32'd0, 32'h0000_0099};
        rf_bus.claim_valid_i = 2'b10;
        rf_bus.claim_addr_i  = {5'd2, 5'd0};
        rf_bus.rs1_addr_i    = {5'd0, 5'd2};
      end
      @(negedge clk);
      if (c == 2) chk("init_busy", 32'(rf_bus.rs1_busy_o), 32'd0);
      if (rf_bus.ready_o === 1'b1) begin
        rise = c;
        clr();
        break;
      end
      step();
    end
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic check_model();
    logic [XLEN-1:0] d;
    logic b;
    chk("ready", 32'(rf_bus.ready_o), (m_cycles >= NREG) ? 32'd1 : 32'd0);
    for (int l = 0; l < NLANE; l++) begin
      model_read(0, l, d, b);
      chk($sformatf("rs1_data[%0d]", l), rf_bus.rs1_data_o[l*XLEN +: XLEN], d);
      chk($sformatf("rs1_busy[%0d]", l), 32'(rf_bus.rs1_busy_o[l]), 32'(b));
      model_read(1, l, d, b);
      chk($sformatf("rs2_data[%0d]", l), rf_bus.rs2_data_o[l*XLEN +: XLEN], d);
      chk($sformatf("rs2_busy[%0d]", l), 32'(rf_bus.rs2_busy_o[l]), 32'(b));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  cv;
    logic [4:0]  ca0, ca1;
    logic [4:0]  ra;
    logic [31:0] exp_d;
    logic        exp_b;
  } vec_t;

  vec_t tbl [11];

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise;
    // row: we wa0 wa1 wd0 wd1 cv ca0 ca1 ra exp_d exp_b (exp is lane0 rs1 in that cycle)
    tbl[0]  = '{2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 2'b00, 5'd0, 5'd0, 5'd5, 32'h0, 1'b0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 5'd0, 5'd0, 5'd5, 32'h22, 1'b0};
    tbl[2]  = '{2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  2'b01, 5'd7, 5'd0, 5'd7, 32'h22, 1'b0};
`ifdef REGFILE_BYPASS_EN
    tbl[3]  = '{2'b10, 5'd0, 5'd7, 32'h0,  32'h77, 2'b01, 5'd7, 5'd0, 5'd7, 32'h77, 1'b1};
    tbl[4]  = '{2'b01, 5'd7, 5'd0, 32'h78, 32'h0,  2'b00, 5'd0, 5'd0, 5'd7, 32'h78, 1'b0};
    tbl[6]  = '{2'b01, 5'd3, 5'd0, 32'hABCD, 32'h0, 2'b00, 5'd0, 5'd0, 5'd3, 32'hABCD, 1'b0};
`else
    tbl[3]  = '{2'b10, 5'd0, 5'd7, 32'h0,  32'h77, 2'b01, 5'd7, 5'd0, 5'd7, 32'h0,  1'b1};
    tbl[4]  = '{2'b01, 5'd7, 5'd0, 32'h78, 32'h0,  2'b00, 5'd0, 5'd0, 5'd7, 32'h77, 1'b1};
    tbl[6]  = '{2'b01, 5'd3, 5'd0, 32'hABCD, 32'h0, 2'b00, 5'd0, 5'd0, 5'd3, 32'h0, 1'b0};
`endif
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 5'd0, 5'd0, 5'd3, 32'h78, 1'b0};
    tbl[7]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 2'b10, 5'd0, 5'd0, 5'd0, 32'hABCD, 1'b0};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0};
    tbl[9]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 2'b01, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0};
    tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0};

    // Reset and sweep timing
    clr();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_ready(1'b0, rise);
    chk("ready_rise_cycle", 32'(rise), 32'(NREG + 1));

    // Every register reads zero after the sweep
    for (int r = 0; r < NREG; r++) begin
      rf_bus.rs1_addr_i = {5'd0, 5'(r)};
      rf_bus.rs2_addr_i = {5'(NREG - 1 - r), 5'd0};
      step();
      @(negedge clk);
      chk($sformatf("zero_rs1_x%0d", r), rf_bus.rs1_data_o[31:0], 32'd0);
      chk($sformatf("zero_rs2_x%0d", NREG - 1 - r), rf_bus.rs2_data_o[63:32], 32'd0);
    end

    // Directed table
    clr();
    step();
    for (int i = 0; i < 11; i++) begin
      rf_bus.rd_write_i    = tbl[i].we;
      rf_bus.rd_addr_i     = {tbl[i].wa1, tbl[i].wa0};
      rf_bus.rd_data_i     = {tbl[i].wd1, tbl[i].wd0};
      rf_bus.claim_valid_i = tbl[i].cv;
      rf_bus.claim_addr_i  = {tbl[i].ca1, tbl[i].ca0};
      rf_bus.rs1_addr_i    = {5'd0, tbl[i].ra};
      rf_bus.rs2_addr_i    = '0;
      @(negedge clk);
      chk($sformatf("tbl%0d_data", i), rf_bus.rs1_data_o[31:0], tbl[i].exp_d);
      chk($sformatf("tbl%0d_busy", i), 32'(rf_bus.rs1_busy_o[0]), 32'(tbl[i].exp_b));
      step();
    end

    // Reset mid-sweep; writes/claims during INIT must be ignored
    clr();
    rf_bus.rd_write_i = 2'b01;
    rf_bus.rd_addr_i  = {5'd0, 5'd1};
    rf_bus.rd_data_i  = {32'd0, 32'h55};
    step();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (9) step();
    @(negedge clk);
    chk("midsweep_ready", 32'(rf_bus.ready_o), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(1'b1, rise);
    chk("restart_rise_cycle", 32'(rise), 32'(NREG + 1));
    rf_bus.rs1_addr_i = {5'd0, 5'd1};
    rf_bus.rs2_addr_i = {5'd0, 5'd2};
    step();
    @(negedge clk);
    chk("init_write_ignored", rf_bus.rs1_data_o[31:0], 32'd0);
    chk("init_claim_ignored", 32'(rf_bus.rs2_busy_o[0]), 32'd0);
    step();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      rf_bus.rd_write_i    = 2'($urandom_range(0, 3));
      rf_bus.rd_data_i     = {$urandom, $urandom};
      rf_bus.claim_valid_i = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int l = 0; l < NLANE; l++) begin
        rf_bus.rd_addr_i[l*AW +: AW]    = raddr();
        rf_bus.claim_addr_i[l*AW +: AW] = raddr();
        rf_bus.rs1_addr_i[l*AW +: AW]   = raddr();
        rf_bus.rs2_addr_i[l*AW +: AW]   = raddr();
      end
      @(negedge clk);
      check_model();
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
